sc_config_regbank: RTL and testbench
====================================

# sc_config_regbank

Parametrised, double-buffered successor to the scan converter configuration register file. It is an Avalon-MM slave with N_STATUS read-only status words and N_CONFIG read/write config words, all with readback. Software writes go to shadow registers. A commit transfers the shadows atomically to the active outputs at the next frame start, so a multi-register mode change never takes effect mid-frame.

## Interface
- N_STATUS, 2: number of read-only status words, at addresses 0..N_STATUS-1.
- N_CONFIG, 13: number of config words, at addresses CFG_BASE..CFG_BASE+N_CONFIG-1.
- ADDR_W, 9: Avalon word-address width.
- CNT_W, 8: width of the commit counter.
- clk_i  in  1  system clock; the only clock.
- rst_n_i  in  1  reset; asynchronous, active-low.
- avalon_s_address  in  ADDR_W  word address.
- avalon_s_writedata  in  32  write data.
- avalon_s_byteenable  in  4  byte lanes.
- avalon_s_write / avalon_s_read / avalon_s_chipselect  in  1 each  Avalon strobes.
- avalon_s_readdata  out  32  registered read data, fixed read latency 1.
- avalon_s_waitrequest_n  out  1  tied 1.
- status_i  in  N_STATUS*32  status words, packed; word k is bits [32k+31:32k].
- frame_start_i  in  1  asynchronous vsync-derived level; a rising edge marks frame start.
- cfg_o  out  N_CONFIG*32  active config words, packed.
- cfg_update_o  out  1  one-cycle pulse on each cycle in which cfg_o changes.
- commit_pending_o  out  1  high while a commit is armed.

## Operation
- Address map:
  - CTRL_ADDR = N_STATUS.
  - CFG_BASE = N_STATUS+1.
  - Every other address reads 0 and ignores writes.
- CTRL write bits:
  - bit0: commit request, write-1.
  - bit1: immediate mode, R/W.
  - bit2: abort, write-1.
- CTRL read value: {commit_cnt[CNT_W-1:0] at [15:8], pending at [2], immediate at [1], 0 elsewhere}.
- Shadow writes: honour each byteenable lane independently. A config read returns the shadow word.
- Commit FSM has two states, IDLE and PENDING:
  - IDLE → PENDING on a commit request with immediate mode = 0.
  - PENDING → IDLE on a frame-start edge. In that same cycle, all active words take their shadow values, cfg_update_o pulses and commit_cnt increments.
  - PENDING → IDLE on abort, with no transfer.
  - A commit request while PENDING has no further effect.
- Immediate mode = 1: each config write updates shadow and active in the same cycle and pulses cfg_update_o. commit_cnt does not change. A commit request in IDLE in this mode is ignored.
- Writing immediate mode = 1 while PENDING forces a transfer that cycle, as if a frame-start edge had arrived.
- frame_start_i passes through a 2-FF synchroniser, then a rising-edge detector.
- commit_cnt is modulo 2^CNT_W and wraps silently.

## Timing
- Reset values:
  - All shadow, active, CTRL, commit_cnt and readdata registers = 0.
  - FSM = IDLE.
  - cfg_update_o = 0, commit_pending_o = 0.
  - Synchroniser flops = 0. A high frame_start_i at reset release therefore yields one edge after sync.
- Read: readdata is valid the cycle after chipselect&&read, and is 0 when no read is in progress.
- Frame-start latency: a rising edge on frame_start_i causes the transfer 3 clk_i cycles later (2 sync + 1 edge register).
- Simultaneous events:
  - Commit request and frame-start edge in the same cycle while IDLE: enter PENDING; commit on the next edge.
  - Config write and transfer in the same cycle: active takes the pre-write shadow. The new value stays in shadow, and pending is not re-armed.
  - Abort and commit request in the same CTRL write: abort wins; the FSM ends in IDLE.
- Reset mid-PENDING: the pending commit is discarded; outputs return to 0 asynchronously.

## Structure
- Package sc_config_pkg holds:
  - CTRL bit-index constants.
  - The FSM state enum.
  - A function computing CFG_BASE from N_STATUS.
- Sub-module sc_sync_edge: 2-FF synchroniser plus rising-edge detector, reusable for other frame-rate strobes.
- The shadow and active arrays are generated in a loop over N_CONFIG in logic (no RAM inference), because all active words are read in parallel.

## Test plan
- Reset then read: all config and CTRL reads return 0, and status reads return status_i. With N_STATUS=2 and status_i word1=32'hCAFE0001, a read of address 1 returns 32'hCAFE0001 one cycle later.
- Byte-lane write: write 32'h11223344 with byteenable=4'b0101 to CFG_BASE after reset. Readback = 32'h00220044; cfg_o is unchanged until commit.
- Deferred commit:
  - Write two config words, then CTRL=1. commit_pending_o=1.
  - Pulse frame_start_i. cfg_o updates exactly 3 cycles after the edge, cfg_update_o pulses once, CTRL[15:8]=1, pending=0.
- Abort: CTRL=1, then CTRL=4 before any edge. pending=0, and a subsequent frame edge leaves cfg_o unchanged.
- Immediate mode: CTRL=2, then write 32'hDEADBEEF to CFG_BASE+3. cfg_o word3 = 32'hDEADBEEF the next cycle, cfg_update_o pulses, and commit_cnt is unchanged.
- Collision and wrap:
  - A config write in the transfer cycle leaves the old value active and the new value in shadow.
  - 256 commits with CNT_W=8 wrap commit_cnt to 0.
  - Asserting rst_n_i low while PENDING clears cfg_o and pending immediately.

Source files
------------

// File: rtl/sc_config_pkg.sv
// Shared constants, types and helpers for the scan converter config register bank.
package sc_config_pkg;

    // CTRL register bit positions (write side)
    localparam int CTRL_COMMIT_BIT  = 0;
    localparam int CTRL_IMM_BIT     = 1;
    localparam int CTRL_ABORT_BIT   = 2;

    // CTRL register bit positions (read side)
    localparam int CTRL_PENDING_BIT = 2;
    localparam int CTRL_CNT_LSB     = 8;

    // Commit sequencer: either nothing is armed, or a commit waits for frame start
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } commit_state_e;

    // Config words sit directly above the status words and the single CTRL word
    function automatic int cfg_base(input int n_status);
        return n_status + 1;
    endfunction

    // Byte-lane merge of a bus write into an existing 32-bit word
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  byte_en);
        logic [31:0] result;
        result = old_word;
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
                result[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sc_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector for slow async strobes
// such as vsync-derived frame markers.
module sc_sync_edge (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic edge_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchroniser chain plus one history flop for edge detection
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each flop sample the previous
            // stage's old value; blocking ones would collapse the chain into one flop.
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // High for exactly one cycle after the synchronised level goes 0 -> 1
    assign edge_o = sync_q & ~prev_q;

endmodule

// File: rtl/sc_config_regbank.sv
// Double-buffered config register bank (Avalon-MM slave). Software writes land in
// shadow registers; a commit copies every shadow word to the active outputs at the
// next frame start so multi-word mode changes are atomic with respect to a frame.
module sc_config_regbank
    import sc_config_pkg::*;
#(
    parameter int N_STATUS = 2,
    parameter int N_CONFIG = 13,
    parameter int ADDR_W   = 9,
    parameter int CNT_W    = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,

    input  logic [ADDR_W-1:0]       avalon_s_address,
    input  logic [31:0]             avalon_s_writedata,
    input  logic [3:0]              avalon_s_byteenable,
    input  logic                    avalon_s_write,
    input  logic                    avalon_s_read,
    input  logic                    avalon_s_chipselect,
    output logic [31:0]             avalon_s_readdata,
    output logic                    avalon_s_waitrequest_n,

    input  logic [N_STATUS*32-1:0]  status_i,
    input  logic                    frame_start_i,
    output logic [N_CONFIG*32-1:0]  cfg_o,
    output logic                    cfg_update_o,
    output logic                    commit_pending_o
);

    localparam int                CFG_BASE    = cfg_base(N_STATUS);
    localparam logic [ADDR_W-1:0] CTRL_ADDR_A = ADDR_W'(N_STATUS);

    logic                wr_en;
    logic                rd_en;
    logic                ctrl_wr;
    logic                commit_req;
    logic                abort_req;
    logic                force_req;
    logic                frame_edge;
    logic                transfer;
    logic                imm_update;

    logic                imm_q;
    logic                imm_d;
    commit_state_e       state_q;
    commit_state_e       state_d;
    logic [CNT_W-1:0]    commit_cnt_q;
    logic                cfg_update_q;
    logic [31:0]         readdata_q;

    logic [31:0]         shadow_q [N_CONFIG];
    logic [31:0]         active_q [N_CONFIG];
    logic [N_CONFIG-1:0] cfg_sel;
    logic [31:0]         ctrl_rd;
    logic [31:0]         rd_mux;

    // Frame-start marker: synchronised and reduced to a single-cycle edge
    sc_sync_edge u_frame_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .async_i (frame_start_i),
        .edge_o  (frame_edge)
    );

    // Bus decode. CTRL bits all live in byte lane 0, so that lane gates the write.
    assign wr_en      = avalon_s_chipselect & avalon_s_write;
    assign rd_en      = avalon_s_chipselect & avalon_s_read;
    assign ctrl_wr    = wr_en && (avalon_s_address == CTRL_ADDR_A) && avalon_s_byteenable[0];
    assign commit_req = ctrl_wr & avalon_s_writedata[CTRL_COMMIT_BIT];
    assign abort_req  = ctrl_wr & avalon_s_writedata[CTRL_ABORT_BIT];
    assign force_req  = ctrl_wr & avalon_s_writedata[CTRL_IMM_BIT];
    assign imm_d      = ctrl_wr ? avalon_s_writedata[CTRL_IMM_BIT] : imm_q;

    // Per-word select for config writes
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch to hold the old value.
        cfg_sel = '0;
        for (int i = 0; i < N_CONFIG; i++) begin
            cfg_sel[i] = wr_en && (avalon_s_address == ADDR_W'(CFG_BASE + i));
        end
    end

    assign imm_update = imm_q & (|cfg_sel);

    // Commit sequencer next state; abort beats both a commit request and a frame edge
    always_comb begin
        state_d  = state_q;
        transfer = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A commit request in immediate mode (including one setting it) is ignored
                if (commit_req && !abort_req && !imm_d) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (abort_req) begin
                    state_d = ST_IDLE;
                end else if (frame_edge || force_req) begin
                    transfer = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state: FSM, immediate-mode flag, commit counter and update strobe
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            imm_q        <= 1'b0;
            commit_cnt_q <= '0;
            cfg_update_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            imm_q        <= imm_d;
            cfg_update_q <= transfer | imm_update;
            if (transfer) begin
                commit_cnt_q <= commit_cnt_q + CNT_W'(1);
            end
        end
    end

    // Shadow and active word arrays, kept in flops so all active words are visible at once
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: these arrays are reset word by word; that is only possible because
            // they are flops, not a RAM, and it guarantees cfg_o is 0 out of reset.
            for (int i = 0; i < N_CONFIG; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CONFIG; i++) begin
                // A transfer copies the pre-write shadow; a same-cycle write stays in shadow
                if (transfer) begin
                    active_q[i] <= shadow_q[i];
                end else if (imm_q && cfg_sel[i]) begin
                    active_q[i] <= merge_bytes(shadow_q[i], avalon_s_writedata, avalon_s_byteenable);
                end
                if (cfg_sel[i]) begin
                    shadow_q[i] <= merge_bytes(shadow_q[i], avalon_s_writedata, avalon_s_byteenable);
                end
            end
        end
    end

    // CTRL readback image
    always_comb begin
        ctrl_rd                              = '0;
        ctrl_rd[CTRL_CNT_LSB +: CNT_W]       = commit_cnt_q;
        ctrl_rd[CTRL_PENDING_BIT]            = (state_q == ST_PENDING);
        ctrl_rd[CTRL_IMM_BIT]                = imm_q;
    end

    // Read mux: status, CTRL, shadow config; unmapped addresses read 0
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < N_STATUS; k++) begin
            if (avalon_s_address == ADDR_W'(k)) begin
                rd_mux = status_i[32*k +: 32];
            end
        end
        if (avalon_s_address == CTRL_ADDR_A) begin
            rd_mux = ctrl_rd;
        end
        for (int k = 0; k < N_CONFIG; k++) begin
            if (avalon_s_address == ADDR_W'(CFG_BASE + k)) begin
                rd_mux = shadow_q[k];
            end
        end
    end

    // Registered read data, zero whenever no read is in flight
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            readdata_q <= '0;
        end else begin
            readdata_q <= rd_en ? rd_mux : 32'h0;
        end
    end

    // Pack active words onto the output bus
    always_comb begin
        cfg_o = '0;
        for (int i = 0; i < N_CONFIG; i++) begin
            cfg_o[32*i +: 32] = active_q[i];
        end
    end

    assign avalon_s_readdata      = readdata_q;
    assign avalon_s_waitrequest_n = 1'b1;
    assign cfg_update_o           = cfg_update_q;
    assign commit_pending_o       = (state_q == ST_PENDING);

endmodule

// File: tb/tb_sc_config_regbank.sv
// Self-checking bench for sc_config_regbank: directed scenarios plus a random mix,
// all compared against a word-level behavioural model of the register bank.
module tb_sc_config_regbank;

    localparam int N_STATUS = 2;
    localparam int N_CONFIG = 13;
    localparam int ADDR_W   = 9;
    localparam int CNT_W    = 8;
    localparam int CTRL_A   = N_STATUS;
    localparam int CFG_A    = N_STATUS + 1;

    logic                   clk_i = 1'b0;
    logic                   rst_n_i = 1'b0;
    logic [ADDR_W-1:0]      avalon_s_address = '0;
    logic [31:0]            avalon_s_writedata = '0;
    logic [3:0]             avalon_s_byteenable = '0;
    logic                   avalon_s_write = 1'b0;
    logic                   avalon_s_read = 1'b0;
    logic                   avalon_s_chipselect = 1'b0;
    logic [31:0]            avalon_s_readdata;
    logic                   avalon_s_waitrequest_n;
    logic [N_STATUS*32-1:0] status_i = '0;
    logic                   frame_start_i = 1'b0;
    logic [N_CONFIG*32-1:0] cfg_o;
    logic                   cfg_update_o;
    logic                   commit_pending_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: shadow/active word arrays plus the few control facts
    logic [31:0] m_sh  [N_CONFIG];
    logic [31:0] m_act [N_CONFIG];
    bit          m_imm;
    bit          m_pend;
    bit          m_upd;
    int          m_cnt;

    sc_config_regbank #(
        .N_STATUS (N_STATUS),
        .N_CONFIG (N_CONFIG),
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i                  (clk_i),
        .rst_n_i                (rst_n_i),
        .avalon_s_address       (avalon_s_address),
        .avalon_s_writedata     (avalon_s_writedata),
        .avalon_s_byteenable    (avalon_s_byteenable),
        .avalon_s_write         (avalon_s_write),
        .avalon_s_read          (avalon_s_read),
        .avalon_s_chipselect    (avalon_s_chipselect),
        .avalon_s_readdata      (avalon_s_readdata),
        .avalon_s_waitrequest_n (avalon_s_waitrequest_n),
        .status_i               (status_i),
        .frame_start_i          (frame_start_i),
        .cfg_o                  (cfg_o),
        .cfg_update_o           (cfg_update_o),
        .commit_pending_o       (commit_pending_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, required completion before it");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    task automatic model_reset();
        for (int k = 0; k < N_CONFIG; k++) begin
            m_sh[k]  = 32'h0;
            m_act[k] = 32'h0;
        end
        m_imm  = 1'b0;
        m_pend = 1'b0;
        m_upd  = 1'b0;
        m_cnt  = 0;
    endtask

    function automatic logic [N_CONFIG*32-1:0] exp_cfg();
        logic [N_CONFIG*32-1:0] r;
        for (int k = 0; k < N_CONFIG; k++) r[32*k +: 32] = m_act[k];
        return r;
    endfunction

    // Frame start (or forced) commit: all shadows become active at once
    task automatic model_transfer();
        if (m_pend) begin
            for (int k = 0; k < N_CONFIG; k++) m_act[k] = m_sh[k];
            m_cnt  = (m_cnt + 1) % (1 << CNT_W);
            m_upd  = 1'b1;
            m_pend = 1'b0;
        end
    endtask

    task automatic model_write(input int addr, input logic [31:0] data, input logic [3:0] be);
        if (addr >= CFG_A && addr < CFG_A + N_CONFIG) begin
            int k;
            k = addr - CFG_A;
            for (int b = 0; b < 4; b++) begin
                if (be[b]) m_sh[k][8*b +: 8] = data[8*b +: 8];
            end
            if (m_imm) begin
                m_act[k] = m_sh[k];
                m_upd    = 1'b1;
            end
        end else if (addr == CTRL_A) begin
            if (m_pend && data[2])       m_pend = 1'b0;
            else if (m_pend && data[1])  model_transfer();
            else if (!m_pend && data[0] && !data[1] && !data[2]) m_pend = 1'b1;
            m_imm = data[1];
        end
    endtask

    function automatic logic [31:0] model_read(input int addr);
        if (addr < N_STATUS)                              return status_i[32*addr +: 32];
        if (addr == CTRL_A)                               return (m_cnt << 8) | (32'(m_pend) << 2) | (32'(m_imm) << 1);
        if (addr >= CFG_A && addr < CFG_A + N_CONFIG)     return m_sh[addr - CFG_A];
        return 32'h0;
    endfunction

    // ---------------- bus / stimulus (all start and end just after a negedge) ----------------
    task automatic do_reset();
        rst_n_i       = 1'b0;
        frame_start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        model_reset();
        @(negedge clk_i);
    endtask

    task automatic bus_write(input int addr, input logic [31:0] data, input logic [3:0] be,
                             input bit with_edge = 1'b0);
        avalon_s_address    = ADDR_W'(addr);
        avalon_s_writedata  = data;
        avalon_s_byteenable = be;
        avalon_s_chipselect = 1'b1;
        avalon_s_write      = 1'b1;
        @(posedge clk_i);
        m_upd = 1'b0;
        if (with_edge) model_transfer();
        model_write(addr, data, be);
        @(negedge clk_i);
        avalon_s_chipselect = 1'b0;
        avalon_s_write      = 1'b0;
    endtask

    task automatic bus_read(input int addr, output logic [31:0] data);
        avalon_s_address    = ADDR_W'(addr);
        avalon_s_chipselect = 1'b1;
        avalon_s_read       = 1'b1;
        @(negedge clk_i);
        data                = avalon_s_readdata;
        avalon_s_chipselect = 1'b0;
        avalon_s_read       = 1'b0;
    endtask

    // Raise frame_start_i and follow the model through the 3-cycle latency
    task automatic frame_pulse();
        frame_start_i = 1'b1;
        for (int p = 1; p <= 4; p++) begin
            @(negedge clk_i);
            m_upd = 1'b0;
            if (p == 3) model_transfer();
            n_tests++;
            if (cfg_o !== exp_cfg() || cfg_update_o !== m_upd || commit_pending_o !== m_pend) begin
                n_fail++;
                $display("FAIL frame_step%0d: cfg=%h upd=%b pend=%b, required cfg=%h upd=%b pend=%b",
                         p, cfg_o, cfg_update_o, commit_pending_o, exp_cfg(), m_upd, m_pend);
            end
        end
        frame_start_i = 1'b0;
        repeat (4) @(negedge clk_i);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] rd;
        do_reset();
        status_i[63:32] = 32'hCAFE0001;
        status_i[31:0]  = $urandom;
        n_tests++;
        if (cfg_o !== '0 || cfg_update_o !== 1'b0 || commit_pending_o !== 1'b0 || avalon_s_readdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: cfg=%h upd=%b pend=%b rd=%h, required all zero",
                     cfg_o, cfg_update_o, commit_pending_o, avalon_s_readdata);
        end
        bus_read(1, rd);
        n_tests++;
        if (rd !== 32'hCAFE0001) begin
            n_fail++; $display("FAIL reset_status1: got %h required %h", rd, 32'hCAFE0001);
        end
        bus_read(0, rd);
        n_tests++;
        if (rd !== status_i[31:0]) begin
            n_fail++; $display("FAIL reset_status0: got %h required %h", rd, status_i[31:0]);
        end
        bus_read(CTRL_A, rd);
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL reset_ctrl: got %h required 0", rd);
        end
        for (int k = 0; k < N_CONFIG; k++) begin
            bus_read(CFG_A + k, rd);
            n_tests++;
            if (rd !== 32'h0) begin
                n_fail++; $display("FAIL reset_cfg%0d: got %h required 0", k, rd);
            end
        end
        @(negedge clk_i);
        n_tests++;
        if (avalon_s_readdata !== 32'h0) begin
            n_fail++; $display("FAIL readdata_idle: got %h required 0", avalon_s_readdata);
        end
    endtask

    task automatic test_byte_lane();
        logic [31:0] rd;
        bus_write(CFG_A, 32'h11223344, 4'b0101);
        bus_read(CFG_A, rd);
        n_tests++;
        if (rd !== 32'h00220044) begin
            n_fail++; $display("FAIL byte_lane_readback: got %h required %h", rd, 32'h00220044);
        end
        n_tests++;
        if (cfg_o !== '0 || cfg_update_o !== 1'b0) begin
            n_fail++; $display("FAIL byte_lane_active: cfg=%h upd=%b, required zero", cfg_o, cfg_update_o);
        end
    endtask

    task automatic test_deferred();
        logic [31:0] rd;
        bus_write(CFG_A + 1, 32'hA5A51234, 4'hF);
        bus_write(CFG_A + 7, 32'h0BADF00D, 4'hF);
        bus_write(CTRL_A, 32'h1, 4'hF);
        n_tests++;
        if (commit_pending_o !== 1'b1 || cfg_o !== '0) begin
            n_fail++; $display("FAIL deferred_armed: pend=%b cfg=%h, required pend=1 cfg=0", commit_pending_o, cfg_o);
        end
        frame_pulse();
        bus_read(CTRL_A, rd);
        n_tests++;
        if (rd !== 32'h00000100) begin
            n_fail++; $display("FAIL deferred_ctrl: got %h required %h", rd, 32'h00000100);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        bus_write(CFG_A + 2, 32'h12345678, 4'hF);
        bus_write(CTRL_A, 32'h1, 4'hF);
        bus_write(CTRL_A, 32'h4, 4'hF);
        n_tests++;
        if (commit_pending_o !== 1'b0) begin
            n_fail++; $display("FAIL abort_pending: got %b required 0", commit_pending_o);
        end
        frame_pulse();
        // abort and commit in one write: abort wins, from IDLE and from PENDING
        bus_write(CTRL_A, 32'h5, 4'hF);
        bus_write(CTRL_A, 32'h1, 4'hF);
        bus_write(CTRL_A, 32'h5, 4'hF);
        bus_read(CTRL_A, rd);
        n_tests++;
        if (rd !== model_read(CTRL_A) || commit_pending_o !== 1'b0) begin
            n_fail++; $display("FAIL abort_with_commit: ctrl=%h pend=%b required ctrl=%h pend=0",
                               rd, commit_pending_o, model_read(CTRL_A));
        end
        frame_pulse();
    endtask

    task automatic test_immediate();
        logic [31:0] rd;
        int          cnt_before;
        cnt_before = m_cnt;
        bus_write(CTRL_A, 32'h2, 4'hF);
        bus_write(CFG_A + 3, 32'hDEADBEEF, 4'hF);
        n_tests++;
        if (cfg_o[32*3 +: 32] !== 32'hDEADBEEF || cfg_update_o !== 1'b1 || cfg_o !== exp_cfg()) begin
            n_fail++; $display("FAIL imm_write: word3=%h upd=%b, required %h upd=1",
                               cfg_o[32*3 +: 32], cfg_update_o, 32'hDEADBEEF);
        end
        @(negedge clk_i);
        n_tests++;
        if (cfg_update_o !== 1'b0) begin
            n_fail++; $display("FAIL imm_pulse_width: upd=%b required 0", cfg_update_o);
        end
        // a commit request in immediate mode is ignored
        bus_write(CTRL_A, 32'h3, 4'hF);
        bus_read(CTRL_A, rd);
        n_tests++;
        if (rd !== ((cnt_before << 8) | 32'h2)) begin
            n_fail++; $display("FAIL imm_ctrl: got %h required %h", rd, (cnt_before << 8) | 32'h2);
        end
        bus_write(CTRL_A, 32'h0, 4'hF);
    endtask

    task automatic test_force_and_collision();
        logic [31:0] rd;
        // writing immediate=1 while PENDING forces a transfer
        bus_write(CFG_A + 4, 32'h44440000, 4'hF);
        bus_write(CTRL_A, 32'h1, 4'hF);
        bus_write(CTRL_A, 32'h2, 4'hF);
        n_tests++;
        if (cfg_o !== exp_cfg() || cfg_update_o !== 1'b1 || commit_pending_o !== 1'b0) begin
            n_fail++; $display("FAIL force_transfer: cfg=%h upd=%b pend=%b, required cfg=%h upd=1 pend=0",
                               cfg_o, cfg_update_o, commit_pending_o, exp_cfg());
        end
        bus_write(CTRL_A, 32'h0, 4'hF);
        // config write landing in the transfer cycle
        bus_write(CFG_A + 5, 32'h0000AAAA, 4'hF);
        bus_write(CTRL_A, 32'h1, 4'hF);
        frame_start_i = 1'b1;
        repeat (2) @(negedge clk_i);
        bus_write(CFG_A + 5, 32'h0000BBBB, 4'hF, 1'b1);
        n_tests++;
        if (cfg_o[32*5 +: 32] !== 32'h0000AAAA || cfg_o !== exp_cfg() || cfg_update_o !== 1'b1 || commit_pending_o !== 1'b0) begin
            n_fail++; $display("FAIL collision_active: word5=%h upd=%b pend=%b, required %h upd=1 pend=0",
                               cfg_o[32*5 +: 32], cfg_update_o, commit_pending_o, 32'h0000AAAA);
        end
        frame_start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        bus_read(CFG_A + 5, rd);
        n_tests++;
        if (rd !== 32'h0000BBBB) begin
            n_fail++; $display("FAIL collision_shadow: got %h required %h", rd, 32'h0000BBBB);
        end
        // commit request on the same cycle as a frame edge in IDLE: arms, fires on the next edge
        frame_start_i = 1'b1;
        repeat (2) @(negedge clk_i);
        bus_write(CTRL_A, 32'h1, 4'hF, 1'b1);
        n_tests++;
        if (commit_pending_o !== 1'b1 || cfg_o !== exp_cfg() || cfg_update_o !== 1'b0) begin
            n_fail++; $display("FAIL commit_at_edge: pend=%b upd=%b, required pend=1 upd=0",
                               commit_pending_o, cfg_update_o);
        end
        frame_start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        frame_pulse();
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic [31:0] exp_rd;
        logic [31:0] ctrl_tab_imm [5];
        logic [31:0] ctrl_tab_idle [5];
        ctrl_tab_imm  = '{32'h0, 32'h2, 32'h6, 32'h4, 32'h0};
        ctrl_tab_idle = '{32'h1, 32'h5, 32'h2, 32'h4, 32'h1};
        for (int it = 0; it < 400; it++) begin
            int op;
            int addr;
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                if ($urandom_range(0, 4) != 0) addr = CFG_A + $urandom_range(0, N_CONFIG - 1);
                else addr = $urandom_range(0, (1 << ADDR_W) - 1);
                if (addr == CTRL_A) addr = CFG_A + N_CONFIG;
                bus_write(addr, $urandom, 4'($urandom_range(0, 15)));
            end else if (op <= 5) begin
                if ($urandom_range(0, 4) != 0) addr = $urandom_range(0, CFG_A + N_CONFIG);
                else addr = $urandom_range(0, (1 << ADDR_W) - 1);
                exp_rd = model_read(addr);
                bus_read(addr, rd);
                n_tests++;
                if (rd !== exp_rd) begin
                    n_fail++; $display("FAIL rand_read@%0d: got %h required %h", addr, rd, exp_rd);
                end
                m_upd = 1'b0;
            end else if (op == 6) begin
                if (m_imm) bus_write(CTRL_A, ctrl_tab_imm[$urandom_range(0, 4)], 4'hF);
                else       bus_write(CTRL_A, ctrl_tab_idle[$urandom_range(0, 4)], 4'hF);
            end else if (op == 7) begin
                frame_pulse();
                m_upd = 1'b0;
            end else begin
                status_i = {$urandom, $urandom};
                @(negedge clk_i);
                m_upd = 1'b0;
            end
            n_tests++;
            if (cfg_o !== exp_cfg() || cfg_update_o !== m_upd || commit_pending_o !== m_pend) begin
                n_fail++;
                $display("FAIL rand_state it%0d: cfg=%h upd=%b pend=%b, required cfg=%h upd=%b pend=%b",
                         it, cfg_o, cfg_update_o, commit_pending_o, exp_cfg(), m_upd, m_pend);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        do_reset();
        bus_write(CFG_A + 6, 32'h66, 4'hF);
        for (int i = 0; i < 256; i++) begin
            bus_write(CTRL_A, 32'h1, 4'hF);
            bus_write(CTRL_A, 32'h2, 4'hF);
            if (cfg_update_o !== 1'b1) begin
                n_fail++; $display("FAIL wrap_update%0d: upd=%b required 1", i, cfg_update_o);
            end
            n_tests++;
            bus_write(CTRL_A, 32'h0, 4'hF);
            if (i == 254) begin
                bus_read(CTRL_A, rd);
                n_tests++;
                if (rd[15:8] !== 8'd255) begin
                    n_fail++; $display("FAIL wrap_cnt255: got %0d required 255", rd[15:8]);
                end
            end
        end
        bus_read(CTRL_A, rd);
        n_tests++;
        if (rd !== 32'h0 || m_cnt != 0) begin
            n_fail++; $display("FAIL wrap_cnt0: got %h required 0", rd);
        end
    endtask

    task automatic test_reset_pending();
        bus_write(CTRL_A, 32'h2, 4'hF);
        bus_write(CFG_A + 8, 32'h88888888, 4'hF);
        bus_write(CTRL_A, 32'h0, 4'hF);
        bus_write(CFG_A + 8, 32'h99999999, 4'hF);
        bus_write(CTRL_A, 32'h1, 4'hF);
        n_tests++;
        if (commit_pending_o !== 1'b1 || cfg_o[32*8 +: 32] !== 32'h88888888) begin
            n_fail++; $display("FAIL rstpend_setup: pend=%b word8=%h, required pend=1 word8=%h",
                               commit_pending_o, cfg_o[32*8 +: 32], 32'h88888888);
        end
        #2;
        rst_n_i = 1'b0;
        #1;
        n_tests++;
        if (cfg_o !== '0 || commit_pending_o !== 1'b0 || cfg_update_o !== 1'b0) begin
            n_fail++; $display("FAIL rstpend_async: cfg=%h pend=%b upd=%b, required all zero",
                               cfg_o, commit_pending_o, cfg_update_o);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        model_reset();
        @(negedge clk_i);
        frame_pulse();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_byte_lane();
        test_deferred();
        test_abort();
        test_immediate();
        test_force_and_collision();
        test_random();
        test_wrap();
        test_reset_pending();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
